// File: rtl/mux_rr_nto1.sv
// -----------------------------------------------------------------------------
// mux_rr_nto1
// N-to-1 multiplexer with a one-word registered output stage. Channel choice
// is either fixed (mode=0, channel sel) or round-robin among valid channels
// (mode=1). The round-robin pointer remembers the last granted channel in
// both modes, so a switch into round-robin resumes after that channel.
//
// Handshake: every channel and the output use valid/ready. A word moves when
// valid and ready are both high in the same cycle. Ready never depends on the
// data. Valid, once raised by this block on the output, stays high with data
// and channel unchanged until accepted or reset.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_data   : N*W flattened channel data, channel i at [i*W +: W]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready, one-hot or zero
//   mode      : 0 = fixed select via sel, 1 = round-robin
//   sel       : channel index for fixed mode
//   out_data  : registered selected word
//   out_chan  : registered index of the source channel
//   out_valid : output holds an unaccepted word (this is the FSM state)
//   out_ready : downstream accept
// -----------------------------------------------------------------------------
module mux_rr_nto1 #(
  parameter  int N  = 8,
  parameter  int W  = 1,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_chan,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] chan_q, chan_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          load_en;
  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic [W-1:0]  grant_data;
  logic [SW:0]   rr_idx;

  // The stage can take a word when empty, or when full and draining this cycle.
  // Held low during reset so no upstream word is consumed and then lost.
  assign load_en = rst_n && ((state_q == ST_EMPTY) || out_ready);

  // Grant selection.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = '0;
    if (!mode) begin
      // Compare against each legal index so an out-of-range sel never matches.
      for (int i = 0; i < N; i++) begin
        if (sel == SW'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SW'(i);
        end
      end
    end else begin
      // Walk offsets from N down to 1 and let later hits overwrite earlier
      // ones, so the smallest offset after ptr wins and ptr itself
      // (offset N) is the last resort.
      for (int k = N; k >= 1; k--) begin
        rr_idx = {1'b0, ptr_q} + (SW+1)'(k);
        if (rr_idx >= (SW+1)'(N)) begin
          rr_idx = rr_idx - (SW+1)'(N);
        end
        if (in_valid[rr_idx[SW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = rr_idx[SW-1:0];
        end
      end
    end
  end

  // Data mux and one-hot ready.
  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SW'(i)) begin
        grant_data  = in_data[i*W +: W];
        in_ready[i] = grant_vld && load_en;
      end
    end
  end

  // Next state for the output stage and pointer.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      if (grant_vld) begin
        state_d = ST_FULL;
        data_d  = grant_data;
        chan_d  = grant_idx;
        ptr_d   = grant_idx;
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
      // Start at N-1 so the first round-robin search begins at channel 0.
      ptr_q   <= SW'(N - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_chan  = chan_q;

endmodule

// File: tb/tb_mux_rr_nto1.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_nto1
// Directed bench for mux_rr_nto1 with N=8, W=8. Channel i carries data
// base+i so the expected out_data follows from the expected channel.
// -----------------------------------------------------------------------------
module tb_mux_rr_nto1;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = 3;

  logic            clk;
  logic            rst_n;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready;

  int checks = 0;
  int errors = 0;

  logic [SW-1:0] exp_q[$];

  mux_rr_nto1 #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking task
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_data(input logic [7:0] base);
    for (int i = 0; i < N; i++) begin
      in_data[i*W +: W] = base + 8'(i);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [SW-1:0] ec;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b0;

    // Reset state, with inputs offering work while reset is low
    in_valid = 8'hFF;
    mode     = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'h00);
    step();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_out_chan", 32'(out_chan), 32'h0);

    // Fixed select of channel 3
    in_valid = 8'h08;
    mode     = 1'b0;
    sel      = 3'd3;
    in_data  = '0;
    in_data[3*W +: W] = 8'hA5;
    out_ready = 1'b1;
    rst_n    = 1'b1;
    #1;
    check("fix_in_ready", 32'(in_ready), 32'h08);
    step();
    check("fix_out_valid", 32'(out_valid), 32'h1);
    check("fix_out_data", 32'(out_data), 32'hA5);
    check("fix_out_chan", 32'(out_chan), 32'h3);
    in_valid = 8'h00;
    step();
    check("fix_drain_valid", 32'(out_valid), 32'h0);

    // Round-robin over all channels from reset, one word per cycle
    do_reset();
    mode      = 1'b1;
    in_valid  = 8'hFF;
    fill_data(8'h10);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) exp_q.push_back(3'(k % 8));
    #1;
    check("rr_first_ready", 32'(in_ready), 32'h01);
    for (int k = 0; k < 10; k++) begin
      step();
      ec = exp_q.pop_front();
      check("rr_seq_chan", 32'(out_chan), 32'(ec));
      check("rr_seq_data", 32'(out_data), 32'(8'h10 + 8'(ec)));
      check("rr_seq_valid", 32'(out_valid), 32'h1);
    end

    // Wrap-around alternation between channels 0 and 7
    do_reset();
    mode     = 1'b1;
    in_valid = 8'h81;
    fill_data(8'h20);
    out_ready = 1'b1;
    exp_q = '{3'd0, 3'd7, 3'd0, 3'd7};
    while (exp_q.size() > 0) begin
      step();
      ec = exp_q.pop_front();
      check("wrap_chan", 32'(out_chan), 32'(ec));
    end

    // Backpressure: hold a full stage for three cycles
    do_reset();
    mode      = 1'b1;
    in_valid  = 8'hFF;
    fill_data(8'h30);
    out_ready = 1'b0;
    step();
    check("bp_load_chan", 32'(out_chan), 32'h0);
    check("bp_load_valid", 32'(out_valid), 32'h1);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        mode = 1'b0;
        sel  = 3'd5;
        fill_data(8'h40);
        #1;
      end
      check("bp_in_ready", 32'(in_ready), 32'h00);
      step();
      check("bp_hold_data", 32'(out_data), 32'h30);
      check("bp_hold_chan", 32'(out_chan), 32'h0);
      check("bp_hold_valid", 32'(out_valid), 32'h1);
    end
    mode = 1'b1;
    fill_data(8'h30);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h02);
    step();
    check("bp_next_chan", 32'(out_chan), 32'h1);
    check("bp_next_data", 32'(out_data), 32'h31);

    // Fixed select of an idle channel, then of a valid one
    mode     = 1'b0;
    sel      = 3'd5;
    in_valid = 8'hDF;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'h00);
    step();
    check("idle_out_valid", 32'(out_valid), 32'h0);
    check("idle_hold_chan", 32'(out_chan), 32'h1);
    in_valid = 8'hFF;
    #1;
    check("sel5_in_ready", 32'(in_ready), 32'h20);
    step();
    check("sel5_valid", 32'(out_valid), 32'h1);
    check("sel5_chan", 32'(out_chan), 32'h5);
    check("sel5_data", 32'(out_data), 32'h35);

    // Pointer follows fixed-mode grants: round-robin resumes after channel 5
    mode = 1'b1;
    #1;
    check("resume_ready", 32'(in_ready), 32'h40);
    step();
    check("resume_chan", 32'(out_chan), 32'h6);

    // Reset mid-operation discards the held word
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'h00);
    step();
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_data", 32'(out_data), 32'h00);
    check("midrst_chan", 32'(out_chan), 32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("postrst_ready", 32'(in_ready), 32'h01);
    step();
    check("postrst_chan", 32'(out_chan), 32'h0);
    check("postrst_valid", 32'(out_valid), 32'h1);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_nto1.md
MUX_RR_NTO1 -- requirements
Module: mux_rr_nto1

Interface
REQ-001 Parameter N, default 8, number of input channels, legal range 2..16.
REQ-002 Parameter W, default 1, data width per channel in bits, legal range 1..32.
REQ-003 Localparam SW = clog2(N), width of channel-index signals; derived, not overridable.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low; sampled on rising clk edge only.
REQ-006 in_data  input  N*W  flattened channel data; channel i occupies bits [i*W+W-1 : i*W].
REQ-007 in_valid  input  N  per-channel valid; bit i set = channel i offers a word.
REQ-008 in_ready  output  N  per-channel ready; at most one bit set in any cycle.
REQ-009 mode  input  1  0 = fixed select via sel, 1 = round-robin among valid channels.
REQ-010 sel  input  SW  channel index used in fixed mode; ignored in round-robin mode.
REQ-011 out_data  output  W  registered selected word.
REQ-012 out_chan  output  SW  registered index of the channel that supplied out_data.
REQ-013 out_valid  output  1  out_data/out_chan hold a word not yet accepted.
REQ-014 out_ready  input  1  downstream accepts the held word when high with out_valid.

Function
REQ-015 A transfer on channel i SHALL occur in a cycle where in_valid[i] and in_ready[i] are both high; a transfer on the output SHALL occur when out_valid and out_ready are both high.
REQ-016 The output stage SHALL be a one-word register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 load_en SHALL be high when the stage is EMPTY, or FULL with out_ready high (same-cycle drain and refill).
REQ-018 Fixed mode: grant SHALL be channel sel if sel < N and in_valid[sel]; otherwise no grant.
REQ-019 Round-robin mode: grant SHALL be the first channel with in_valid set, searching ptr+1, ptr+2, ... cyclically, wrapping from N-1 to 0, ptr itself checked last.
REQ-020 in_ready[g] SHALL equal load_en for the granted channel g and all other in_ready bits SHALL be 0; in_ready is combinational from in_valid, mode, sel, ptr, out_valid, out_ready.
REQ-021 On load_en with grant g: out_data <= in_data[g], out_chan <= g, out_valid <= 1, ptr <= g.
REQ-022 On load_en with no grant: out_valid <= 0; out_data, out_chan, ptr unchanged.
REQ-023 When FULL and out_ready low: out_data, out_chan, out_valid, ptr SHALL hold, in_ready SHALL be all-zero.
REQ-024 Latency SHALL be exactly one cycle from input transfer to out_valid high; throughput one word per cycle while out_ready stays high.
REQ-025 ptr SHALL update in both modes, so switching to round-robin continues after the last granted channel.
REQ-026 A change of mode or sel SHALL affect only the grant in that same cycle; a held output word SHALL never be altered.
REQ-027 sel >= N (non-power-of-two N) SHALL never grant and never index out of range.

Reset
REQ-028 While rst_n is low at a rising edge: out_valid <= 0, out_data <= 0, out_chan <= 0, ptr <= N-1 (first round-robin search starts at channel 0).
REQ-029 While rst_n is low, in_ready SHALL be all-zero; a held word SHALL be discarded by a reset asserted mid-operation.

Verification (N=8, W=8)
REQ-030 Reset, then mode=0, sel=3, in_valid=8'h08, ch3=8'hA5, out_ready=1 -> in_ready=8'h08; next cycle out_valid=1, out_data=8'hA5, out_chan=3.
REQ-031 mode=1, in_valid=8'hFF held, out_ready=1 for 10 cycles from reset -> out_chan sequence 0,1,...,7,0,1.
REQ-032 mode=1, in_valid=8'h81, ptr=7 -> grant ch0, then ch7, then ch0 (wrap-around alternation).
REQ-033 FULL with out_ready=0 for 3 cycles while in_valid=8'hFF -> in_ready=0, out_data/out_chan stable; out_ready=1 -> held word accepted and next word loaded same cycle.
REQ-034 mode=0, sel=5, in_valid[5]=0 -> in_ready=0, out_valid falls after drain; sel=5 with in_valid[5]=1 -> load next cycle.
REQ-035 rst_n low for one cycle while FULL with out_chan=6 -> out_valid=0, out_data=0, out_chan=0; with mode=1 and in_valid=8'hFF, first grant after release is channel 0.
